axis_misc_decoder: RTL and testbench

- Receive-side counterpart of the misc-data tagger on the TX stream.
- Samples the misc bits that arrive alongside the RX AXI-Stream and recovers two fields:
  - the fast serial pulse ID, a 40-bit frame on bit 1, framed by bit 2;
  - the slow UART-coded pulse counter on bit 0.
- Passes the sample stream through unchanged and presents the recovered values as registered words with one-cycle valid strobes, for tagging and capture logic downstream.

---
 rtl/axis_misc_decoder.sv | 190 +++++++++++++++++++
 tb/tb_axis_misc_decoder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_misc_decoder.sv
// RX-side misc-data decoder: passes the sample stream through and recovers the fast serial
// pulse ID (misc[1] framed by misc[2]) and the slow UART-coded pulse counter (misc[0]).
module axis_misc_decoder #(
    parameter int S_AXIS_TDATA_WIDTH = 32,
    parameter int MISC_WIDTH         = 8,
    parameter int PULSE_ID_WIDTH     = 40,
    parameter int BIT_PERIOD         = 63
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [MISC_WIDTH-1:0]         misc_data,
    output logic                          s_axis_tready,
    input  logic [S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                          s_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [S_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tvalid,
    output logic [PULSE_ID_WIDTH-1:0]     pulse_id,
    output logic                          pulse_id_valid,
    output logic [34:0]                   uart_word,
    output logic                          uart_valid,
    output logic [15:0]                   frame_errors
);

    localparam int IDX_W = $clog2(PULSE_ID_WIDTH);
    localparam int PRE_W = $clog2(BIT_PERIOD);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PULSE_ID_WIDTH - 1);
    localparam logic [PRE_W-1:0] HALF_PRE = PRE_W'((BIT_PERIOD - 1) / 2);
    localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(BIT_PERIOD - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_BITS  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic                      enbl;
    logic                      beat;
    logic                      uart_line;
    logic                      fast_data;
    logic                      fast_mark;
    logic                      unused_misc;

    logic [IDX_W-1:0]          fidx;
    logic [PULSE_ID_WIDTH-1:0] shift;

    logic [1:0]                state;
    logic [PRE_W-1:0]          presc;
    logic [2:0]                bit_cnt;
    logic [7:0]                rx_byte;
    logic [2:0]                byte_idx;
    logic [27:0]               word_buf;

    logic                      fast_err;
    logic                      uart_err;
    logic [16:0]               err_sum;

    assign uart_line   = misc_data[0];
    assign fast_data   = misc_data[1];
    assign fast_mark   = misc_data[2];
    assign unused_misc = ^misc_data[MISC_WIDTH-1:3];

    assign s_axis_tready = enbl & m_axis_tready;
    assign m_axis_tvalid = enbl & s_axis_tvalid;
    assign m_axis_tdata  = s_axis_tdata;
    assign beat          = s_axis_tvalid & s_axis_tready;

    always_ff @(posedge aclk) begin
        if (!aresetn) enbl <= 1'b0;
        else          enbl <= 1'b1;
    end

    // Fast frame: a marker-0 beat always starts a new frame; index 0 means no frame active.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            fidx           <= '0;
            shift          <= '0;
            pulse_id       <= '0;
            pulse_id_valid <= 1'b0;
        end else begin
            pulse_id_valid <= 1'b0;
            if (beat) begin
                if (!fast_mark) begin
                    fidx     <= IDX_W'(1);
                    shift[0] <= fast_data;
                end else if (fidx != '0) begin
                    shift[fidx] <= fast_data;
                    if (fidx == LAST_IDX) begin
                        pulse_id       <= {fast_data, shift[PULSE_ID_WIDTH-2:0]};
                        pulse_id_valid <= 1'b1;
                        fidx           <= '0;
                    end else begin
                        fidx <= fidx + 1'b1;
                    end
                end
            end
        end
    end

    // UART receiver samples each bit near its middle, anchored on the start-bit edge.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state      <= S_IDLE;
            presc      <= '0;
            bit_cnt    <= '0;
            rx_byte    <= '0;
            byte_idx   <= '0;
            word_buf   <= '0;
            uart_word  <= '0;
            uart_valid <= 1'b0;
        end else begin
            uart_valid <= 1'b0;
            if (beat) begin
                case (state)
                    S_IDLE: begin
                        if (!uart_line) begin
                            state <= S_START;
                            presc <= '0;
                        end
                    end
                    S_START: begin
                        if (presc == HALF_PRE) begin
                            presc   <= '0;
                            bit_cnt <= '0;
                            state   <= uart_line ? S_IDLE : S_BITS;
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                    S_BITS: begin
                        if (presc == LAST_PRE) begin
                            presc   <= '0;
                            rx_byte <= {uart_line, rx_byte[7:1]};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 3'd7) state <= S_STOP;
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                    default: begin
                        if (presc == LAST_PRE) begin
                            presc <= '0;
                            state <= S_IDLE;
                            if (!uart_line) begin
                                byte_idx <= '0;
                            end else if (rx_byte[7]) begin
                                word_buf[6:0] <= rx_byte[6:0];
                                byte_idx      <= 3'd1;
                            end else begin
                                case (byte_idx)
                                    3'd1: begin
                                        word_buf[13:7] <= rx_byte[6:0];
                                        byte_idx       <= 3'd2;
                                    end
                                    3'd2: begin
                                        word_buf[20:14] <= rx_byte[6:0];
                                        byte_idx        <= 3'd3;
                                    end
                                    3'd3: begin
                                        word_buf[27:21] <= rx_byte[6:0];
                                        byte_idx        <= 3'd4;
                                    end
                                    3'd4: begin
                                        uart_word  <= {rx_byte[6:0], word_buf};
                                        uart_valid <= 1'b1;
                                        byte_idx   <= '0;
                                    end
                                    default: byte_idx <= '0;
                                endcase
                            end
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign fast_err = beat & ~fast_mark & (fidx != '0);
    assign uart_err = beat & (state == S_STOP) & (presc == LAST_PRE) & ~uart_line;
    assign err_sum  = {1'b0, frame_errors} + {15'd0, fast_err} + {15'd0, uart_err};

    // Both error sources can fire on the same beat, so the counter adds up to two at once.
    always_ff @(posedge aclk) begin
        if (!aresetn)         frame_errors <= '0;
        else if (err_sum[16]) frame_errors <= 16'hFFFF;
        else                  frame_errors <= err_sum[15:0];
    end

endmodule

// File: tb/tb_axis_misc_decoder.sv
// Directed testbench for axis_misc_decoder: passthrough handshake, fast pulse-ID frames
// (clean, stalled, truncated) and UART word assembly including a bad stop bit.
module tb_axis_misc_decoder;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [7:0]  misc_data;
    logic        s_axis_tready;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        m_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic [39:0] pulse_id;
    logic        pulse_id_valid;
    logic [34:0] uart_word;
    logic        uart_valid;
    logic [15:0] frame_errors;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int pid_cnt  = 0;
    int uart_cnt = 0;
    int pid_cyc  = 0;

    axis_misc_decoder dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .misc_data      (misc_data),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .pulse_id       (pulse_id),
        .pulse_id_valid (pulse_id_valid),
        .uart_word      (uart_word),
        .uart_valid     (uart_valid),
        .frame_errors   (frame_errors)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    always @(negedge aclk) begin
        if (pulse_id_valid) begin
            pid_cnt = pid_cnt + 1;
            pid_cyc = cyc;
        end
        if (uart_valid) uart_cnt = uart_cnt + 1;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks = checks + 1;
        if (observed !== expected) begin
            failures = failures + 1;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs and advances just past the next rising edge.
    task automatic applyStimulus(input logic [2:0] misc, input logic tv, input logic mr);
        misc_data     = {5'd0, misc};
        s_axis_tvalid = tv;
        m_axis_tready = mr;
        s_axis_tdata  = $urandom;
        @(posedge aclk);
        #1;
    endtask

    task automatic idleBeats(input int n);
        for (int i = 0; i < n; i++) applyStimulus(3'b101, 1'b1, 1'b1);
    endtask

    task automatic resetDut();
        aresetn       = 1'b0;
        misc_data     = 8'h05;
        s_axis_tvalid = 1'b1;
        m_axis_tready = 1'b1;
        s_axis_tdata  = 32'h0;
        for (int i = 0; i < 4; i++) begin
            @(posedge aclk);
            #1;
            checkOutput("rst_tready", {63'd0, s_axis_tready}, 64'd0);
        end
        checkOutput("rst_pulse_id", {24'd0, pulse_id}, 64'd0);
        checkOutput("rst_uart_word", {29'd0, uart_word}, 64'd0);
        checkOutput("rst_errors", {48'd0, frame_errors}, 64'd0);
        checkOutput("rst_mvalid", {63'd0, m_axis_tvalid}, 64'd0);
        aresetn = 1'b1;
        #1;
        checkOutput("post_rst_tready", {63'd0, s_axis_tready}, 64'd0);
        @(posedge aclk);
        #1;
        checkOutput("enbl_tready", {63'd0, s_axis_tready}, 64'd1);
    endtask

    // Sends nbits of a fast frame; with stall set, inserts three tvalid gaps and two tready gaps.
    task automatic sendFrame(input logic [39:0] value, input int nbits, input logic stall);
        for (int k = 0; k < nbits; k++) begin
            if (stall && (k == 5 || k == 12 || k == 20)) begin
                misc_data     = 8'h00;
                s_axis_tvalid = 1'b0;
                m_axis_tready = 1'b1;
                #1;
                checkOutput("gap_mvalid", {63'd0, m_axis_tvalid}, 64'd0);
                @(posedge aclk);
                #1;
            end
            if (stall && (k == 25 || k == 33)) begin
                misc_data     = 8'h00;
                s_axis_tvalid = 1'b1;
                m_axis_tready = 1'b0;
                #1;
                checkOutput("gap_sready", {63'd0, s_axis_tready}, 64'd0);
                @(posedge aclk);
                #1;
            end
            applyStimulus({(k != 0), value[k], 1'b1}, 1'b1, 1'b1);
        end
    endtask

    task automatic sendUartByte(input logic [6:0] d, input logic flag, input logic stop_ok);
        logic [10:0] bits;
        bits = {1'b1, stop_ok, flag, d, 1'b0};
        for (int i = 0; i < 11; i++)
            for (int j = 0; j < 63; j++) applyStimulus({2'b10, bits[i]}, 1'b1, 1'b1);
    endtask

    initial begin
        logic [1:0]  hs [4];
        logic [34:0] exp_word;
        int          start_cyc;
        int          base_pid;
        int          base_uart;

        hs[0] = 2'b00; hs[1] = 2'b01; hs[2] = 2'b10; hs[3] = 2'b11;

        resetDut();

        for (int i = 0; i < 4; i++) begin
            misc_data     = 8'h05;
            s_axis_tvalid = hs[i][1];
            m_axis_tready = hs[i][0];
            s_axis_tdata  = $urandom;
            #1;
            checkOutput("pass_tdata", {32'd0, m_axis_tdata}, {32'd0, s_axis_tdata});
            checkOutput("pass_mvalid", {63'd0, m_axis_tvalid}, {63'd0, hs[i][1]});
            checkOutput("pass_sready", {63'd0, s_axis_tready}, {63'd0, hs[i][0]});
            @(posedge aclk);
            #1;
        end

        start_cyc = cyc;
        base_pid  = pid_cnt;
        sendFrame(40'h00_0000_0005, 40, 1'b0);
        idleBeats(100);
        checkOutput("fast_pid", {24'd0, pulse_id}, 64'h5);
        checkOutput("fast_strobes", 64'(pid_cnt - base_pid), 64'd1);
        checkOutput("fast_latency", 64'(pid_cyc - start_cyc), 64'd40);
        checkOutput("fast_errors", {48'd0, frame_errors}, 64'd0);

        resetDut();
        start_cyc = cyc;
        base_pid  = pid_cnt;
        sendFrame(40'h00_0000_0005, 40, 1'b1);
        idleBeats(20);
        checkOutput("stall_pid", {24'd0, pulse_id}, 64'h5);
        checkOutput("stall_strobes", 64'(pid_cnt - base_pid), 64'd1);
        checkOutput("stall_latency", 64'(pid_cyc - start_cyc), 64'd45);
        checkOutput("stall_errors", {48'd0, frame_errors}, 64'd0);

        resetDut();
        base_pid = pid_cnt;
        sendFrame(40'hFF_FFFF_FFFF, 20, 1'b0);
        sendFrame(40'hAB_CDEF_0123, 40, 1'b0);
        idleBeats(10);
        checkOutput("trunc_errors", {48'd0, frame_errors}, 64'd1);
        checkOutput("trunc_pid", {24'd0, pulse_id}, 64'hAB_CDEF_0123);
        checkOutput("trunc_strobes", 64'(pid_cnt - base_pid), 64'd1);

        resetDut();
        base_pid  = pid_cnt;
        base_uart = uart_cnt;
        idleBeats(70);
        sendUartByte(7'h01, 1'b1, 1'b1);
        sendUartByte(7'h02, 1'b0, 1'b1);
        sendUartByte(7'h03, 1'b0, 1'b1);
        sendUartByte(7'h04, 1'b0, 1'b1);
        sendUartByte(7'h05, 1'b0, 1'b1);
        idleBeats(70);
        exp_word = {7'h05, 7'h04, 7'h03, 7'h02, 7'h01};
        checkOutput("uart_word", {29'd0, uart_word}, {29'd0, exp_word});
        checkOutput("uart_strobes", 64'(uart_cnt - base_uart), 64'd1);
        checkOutput("uart_errors", {48'd0, frame_errors}, 64'd0);
        checkOutput("uart_no_pid", 64'(pid_cnt - base_pid), 64'd0);

        resetDut();
        base_uart = uart_cnt;
        idleBeats(70);
        sendUartByte(7'h01, 1'b1, 1'b1);
        sendUartByte(7'h02, 1'b0, 1'b1);
        sendUartByte(7'h03, 1'b0, 1'b0);
        sendUartByte(7'h04, 1'b0, 1'b1);
        sendUartByte(7'h05, 1'b0, 1'b1);
        idleBeats(70);
        checkOutput("badstop_strobes", 64'(uart_cnt - base_uart), 64'd0);
        checkOutput("badstop_errors", {48'd0, frame_errors}, 64'd1);
        checkOutput("badstop_word", {29'd0, uart_word}, 64'd0);
        sendUartByte(7'h11, 1'b1, 1'b1);
        sendUartByte(7'h22, 1'b0, 1'b1);
        sendUartByte(7'h33, 1'b0, 1'b1);
        sendUartByte(7'h44, 1'b0, 1'b1);
        sendUartByte(7'h55, 1'b0, 1'b1);
        idleBeats(70);
        exp_word = {7'h55, 7'h44, 7'h33, 7'h22, 7'h11};
        checkOutput("recover_word", {29'd0, uart_word}, {29'd0, exp_word});
        checkOutput("recover_strobes", 64'(uart_cnt - base_uart), 64'd1);
        checkOutput("recover_errors", {48'd0, frame_errors}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
